wb_gpio: RTL and testbench

- Wishbone classic slave GPIO controller on the picorv32 SoC data bus.
- Drives the board LED[2:0] and IO[7:0] pins, which are currently unconnected at board top.
- Provides output/direction registers, atomic set/clear, synchronised input readback and per-pin edge-detect interrupt.
- Board top builds tristates from gpio_o/gpio_oe; irq_o goes to the CPU IRQ line.

---
 rtl/wb_gpio_pkg.sv | 33 +++
 rtl/gpio_edge_sync.sv | 39 +++
 rtl/wb_gpio.sv | 131 +++++++++++++
 tb/tb_wb_gpio.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_gpio_pkg : register map and byte-lane merge helper for wb_gpio    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package wb_gpio_pkg;

    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_OE      = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_STAT    = 3'd5;
    localparam logic [2:0] GPIO_OUT_SET = 3'd6;
    localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

    // Take each byte from data where its lane is enabled, otherwise keep old.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) begin
                merged[8*n +: 8] = data[8*n +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_edge_sync : two-flop pad synchroniser with rise/fall detection  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module gpio_edge_sync #(
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pads,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= pads;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule
`default_nettype wire

// File: rtl/wb_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_gpio  : Wishbone classic GPIO slave with edge-detect interrupt    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int                  GPIO_WIDTH = 11,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET = '0,
    parameter logic [GPIO_WIDTH-1:0] OE_RESET  = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq_o
);

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] oe_q;
    logic [GPIO_WIDTH-1:0] rise_en_q;
    logic [GPIO_WIDTH-1:0] fall_en_q;
    logic [GPIO_WIDTH-1:0] stat_q;
    logic [GPIO_WIDTH-1:0] in_sync;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] stat_next;

    logic        req;
    logic        wr;
    logic [31:0] out_ext;
    logic [31:0] cur_rw;
    logic [31:0] rw_val;
    logic [31:0] set_val;
    logic [31:0] clr_val;
    logic [31:0] w1c_mask;
    logic [31:0] rdata;

    gpio_edge_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_edge_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pads    (gpio_i),
        .sync    (in_sync),
        .rise    (rise),
        .fall    (fall)
    );

    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = req & wb_we_i;
    assign out_ext = 32'(out_q);

    always_comb begin
        cur_rw = '0;
        rdata  = '0;
        case (wb_adr_i)
            GPIO_OUT:     begin cur_rw = out_ext;          rdata = out_ext;          end
            GPIO_OE:      begin cur_rw = 32'(oe_q);        rdata = 32'(oe_q);        end
            GPIO_IN:      begin                            rdata = 32'(in_sync);     end
            GPIO_RISE_EN: begin cur_rw = 32'(rise_en_q);   rdata = 32'(rise_en_q);   end
            GPIO_FALL_EN: begin cur_rw = 32'(fall_en_q);   rdata = 32'(fall_en_q);   end
            GPIO_STAT:    begin                            rdata = 32'(stat_q);      end
            default:      begin                                                      end
        endcase
    end

    // Every write flavour passes through the same byte-lane merge.
    assign rw_val   = apply_sel(cur_rw, wb_dat_i, wb_sel_i);
    assign set_val  = apply_sel(out_ext, out_ext | wb_dat_i, wb_sel_i);
    assign clr_val  = apply_sel(out_ext, out_ext & ~wb_dat_i, wb_sel_i);
    assign w1c_mask = (wr && wb_adr_i == GPIO_STAT) ? apply_sel(32'h0, wb_dat_i, wb_sel_i) : 32'h0;

    // A fresh edge overrides a simultaneous write-one-to-clear of the same bit.
    assign stat_next = (stat_q & ~w1c_mask[GPIO_WIDTH-1:0])
                     | (rise & rise_en_q)
                     | (fall & fall_en_q);

    generate
        if (GPIO_WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{rw_val[31:GPIO_WIDTH], set_val[31:GPIO_WIDTH],
                                 clr_val[31:GPIO_WIDTH], w1c_mask[31:GPIO_WIDTH]};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= OUT_RESET;
            oe_q      <= OE_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            irq_o     <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : 32'h0;
            if (wr) begin
                case (wb_adr_i)
                    GPIO_OUT:     out_q     <= rw_val[GPIO_WIDTH-1:0];
                    GPIO_OE:      oe_q      <= rw_val[GPIO_WIDTH-1:0];
                    GPIO_RISE_EN: rise_en_q <= rw_val[GPIO_WIDTH-1:0];
                    GPIO_FALL_EN: fall_en_q <= rw_val[GPIO_WIDTH-1:0];
                    GPIO_OUT_SET: out_q     <= set_val[GPIO_WIDTH-1:0];
                    GPIO_OUT_CLR: out_q     <= clr_val[GPIO_WIDTH-1:0];
                    default:      ;
                endcase
            end
            stat_q <= stat_next;
            irq_o  <= |stat_q;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_gpio : scoreboard bench for wb_gpio bus, pins and interrupt    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_wb_gpio;
    import wb_gpio_pkg::*;

    localparam int W = 11;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [3:0]    wb_sel_i = '0;
    logic          wb_we_i  = 1'b0;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [W-1:0]  gpio_i = '0;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_oe;
    logic          irq_o;

    wb_gpio #(
        .GPIO_WIDTH (W),
        .OUT_RESET  (11'h005),
        .OE_RESET   (11'h000)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq_o    (irq_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && wb_ack_o) begin
            if (sbq.size() == 0) begin
                check("spurious_ack", 32'(wb_ack_o), 32'h0);
            end else begin
                e = sbq.pop_front();
                if (e.chk) check(e.name, wb_dat_o, e.exp);
            end
        end
    end

    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clock); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        e.chk  = !we;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
        @(posedge clock); #1;
        check({name, "_ack"}, 32'(wb_ack_o), 32'h1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clock); #1;
        check({name, "_ack_drop"}, 32'(wb_ack_o), 32'h0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string name);
        bus(1'b1, adr, dat, sel, 32'h0, name);
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, 4'hF, exp, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_gpio_o", 32'(gpio_o), 32'h005);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h000);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        @(negedge clock) reset_n = 1'b1;
        rd(GPIO_IN, 32'h000, "rd_in_reset");

        // Byte-lane gated write, then full OE write
        wr(GPIO_OUT, 32'h7FF, 4'b0001, "wr_out_lane0");
        wr(GPIO_OE, 32'h0FF, 4'b1111, "wr_oe");
        check("pin_gpio_o", 32'(gpio_o), 32'h0FF);
        check("pin_gpio_oe", 32'(gpio_oe), 32'h0FF);

        // Set/clear and write-only readback
        wr(GPIO_OUT, 32'h0F0, 4'hF, "wr_out");
        wr(GPIO_OUT_SET, 32'h003, 4'hF, "wr_set");
        wr(GPIO_OUT_CLR, 32'h010, 4'hF, "wr_clr");
        rd(GPIO_OUT, 32'h0E3, "rd_out_setclr");
        wr(GPIO_OUT_CLR, 32'h0E3, 4'b0010, "wr_clr_lane1");
        rd(GPIO_OUT, 32'h0E3, "rd_out_lanegate");
        wr(GPIO_OUT_SET, 32'h000, 4'hF, "wr_set_zero");
        rd(GPIO_OUT_SET, 32'h0, "rd_addr6");
        rd(GPIO_OUT_CLR, 32'h0, "rd_addr7");
        wr(GPIO_FALL_EN, 32'hFFFF_FFFF, 4'hF, "wr_fallen_all");
        rd(GPIO_FALL_EN, 32'h7FF, "rd_fallen_width");
        wr(GPIO_FALL_EN, 32'h0, 4'hF, "wr_fallen_zero");
        wr(GPIO_IN, 32'h7FF, 4'hF, "wr_in_ignored");
        rd(GPIO_IN, 32'h000, "rd_in_ro");

        // Rising edge on pin 0: STAT at N+3, irq at N+4
        wr(GPIO_RISE_EN, 32'h001, 4'hF, "wr_riseen");
        @(posedge clock); #1;
        gpio_i[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            if (k >= 3) check($sformatf("irq_edge_n%0d", k), 32'(irq_o), (k == 4) ? 32'h1 : 32'h0);
        end
        rd(GPIO_IN, 32'h001, "rd_in_pin0");
        rd(GPIO_STAT, 32'h001, "rd_stat_rise");
        gpio_i[1] = 1'b1;
        repeat (5) @(posedge clock);
        rd(GPIO_STAT, 32'h001, "rd_stat_noen");
        rd(GPIO_IN, 32'h003, "rd_in_pin01");

        // Fall on pin 2 colliding with a W1C of the same bit
        wr(GPIO_FALL_EN, 32'h004, 4'hF, "wr_fallen");
        gpio_i[2] = 1'b1;
        repeat (5) @(posedge clock);
        wr(GPIO_STAT, 32'h001, 4'hF, "w1c_bit0");
        check("irq_after_w1c0", 32'(irq_o), 32'h0);
        rd(GPIO_STAT, 32'h000, "rd_stat_clr0");
        @(posedge clock); #1;
        gpio_i[2] = 1'b0;
        @(posedge clock);
        wr(GPIO_STAT, 32'h004, 4'hF, "w1c_collide");
        check("irq_collide", 32'(irq_o), 32'h1);
        rd(GPIO_STAT, 32'h004, "rd_stat_collide");
        wr(GPIO_STAT, 32'h004, 4'b0010, "w1c_wrong_lane");
        rd(GPIO_STAT, 32'h004, "rd_stat_lane");
        wr(GPIO_STAT, 32'h004, 4'b0001, "w1c_bit2");
        check("irq_after_w1c2", 32'(irq_o), 32'h0);
        rd(GPIO_STAT, 32'h000, "rd_stat_clr2");

        // Reset during an acked OE write
        @(posedge clock); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = GPIO_OE;
        wb_dat_i = 32'h03C;
        wb_sel_i = 4'hF;
        @(posedge clock); #1;
        check("midrst_ack_rise", 32'(wb_ack_o), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_ack_drop", 32'(wb_ack_o), 32'h0);
        check("midrst_oe", 32'(gpio_oe), 32'h000);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        rd(GPIO_OE, 32'h000, "rd_oe_after_rst");
        rd(GPIO_OUT, 32'h005, "rd_out_after_rst");

        repeat (2) @(posedge clock);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
